// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg
//   Shared types for the 5-stage pipeline hazard logic.
//   stage_tag_t : full hazard tag of the instruction in EX
//                 {valid, regWrite, memRead, multi, rd, rs[NUM_RD], used}
//   dst_tag_t   : destination-only tag carried by MEM and WB; forwarding
//                 from those stages needs nothing but the write side
//   fwd_sel_e   : EX operand source (regfile / WB / MEM)
//   REG_ZERO    : hard-wired zero register, never a forwarding source
//   The tag layout fixes the register address width and read-port count;
//   hazard_forward_unit takes its REG_AW / NUM_RD defaults from here.
package mips_pipe_pkg;

  localparam int TAG_REG_AW = 5;
  localparam int TAG_NUM_RD = 2;

  localparam logic [TAG_REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic                                   valid;
    logic                                   regWrite;
    logic                                   memRead;
    logic                                   multi;
    logic [TAG_REG_AW-1:0]                  rd;
    logic [TAG_NUM_RD-1:0][TAG_REG_AW-1:0]  rs;
    logic [TAG_NUM_RD-1:0]                  used;
  } stage_tag_t;

  typedef struct packed {
    logic                  valid;
    logic                  regWrite;
    logic [TAG_REG_AW-1:0] rd;
  } dst_tag_t;

  localparam stage_tag_t TAG_BUBBLE = '0;
  localparam dst_tag_t   DST_BUBBLE = '0;

  function automatic dst_tag_t dstOf(input stage_tag_t t);
    dst_tag_t d;
    d.valid    = t.valid;
    d.regWrite = t.regWrite;
    d.rd       = t.rd;
    return d;
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux
//   3:1 operand select for one EX read port.
//   Ports:
//     sel      in  fwd_sel_e    FWD_RF / FWD_WB / FWD_MEM
//     rfData   in  DATA_W       operand read from the regfile (ID/EX)
//     wbData   in  DATA_W       WB mux output
//     memData  in  DATA_W       EX/MEM ALU result
//     opnd     out DATA_W       selected operand
module operand_fwd_mux
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  fwd_sel_e          sel,
  input  logic [DATA_W-1:0] rfData,
  input  logic [DATA_W-1:0] wbData,
  input  logic [DATA_W-1:0] memData,
  output logic [DATA_W-1:0] opnd
);

  always_comb begin
    opnd = rfData;
    case (sel)
      FWD_MEM: opnd = memData;
      FWD_WB:  opnd = wbData;
      default: opnd = rfData;
    endcase
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Data-hazard controller for the 5-stage MIPS pipeline. Tracks the
//   EX/MEM/WB destination tags, forwards EX operands from EX/MEM or MEM/WB,
//   interlocks load-use and multi-cycle (mul/div) ops and applies branch
//   flush. Sits beside ID/EX; drives PC/IFID hold and the EX operand muxes.
//   Optional build macro: HAZARD_PERF_EN adds saturating perf counters.
//   Ports:
//     Clk, Reset       clock (rising) / asynchronous active-high reset
//     id_*             decoded instruction currently in ID
//     ex_branch_taken  branch in EX resolved taken
//     ex_rs_data       regfile operands held in ID/EX, port i at [i*DATA_W]
//     exmem_result     EX/MEM ALU result
//     memwb_result     WB mux output
//     ex_opnd          forwarded EX operands, port i at [i*DATA_W]
//     fwd_sel          per port 2 bits: 0 regfile, 1 WB, 2 MEM
//     stall            hold PC and IF/ID
//     flush            squash IF/ID and the ID instruction
//     perf_stall_cnt   (HAZARD_PERF_EN) cycles with stall=1
//     perf_fwd_cnt     (HAZARD_PERF_EN) cycles with any fwd_sel!=0
module hazard_forward_unit
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = TAG_REG_AW,
  parameter int NUM_RD  = TAG_NUM_RD,
  parameter int MUL_LAT = 4
`ifdef HAZARD_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     id_valid,
  input  logic [NUM_RD*REG_AW-1:0] id_rs_addr,
  input  logic [NUM_RD-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]        id_rd_addr,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_multi,
  input  logic                     ex_branch_taken,
  input  logic [NUM_RD*DATA_W-1:0] ex_rs_data,
  input  logic [DATA_W-1:0]        exmem_result,
  input  logic [DATA_W-1:0]        memwb_result,
  output logic [NUM_RD*DATA_W-1:0] ex_opnd,
  output logic [NUM_RD*2-1:0]      fwd_sel,
  output logic                     stall,
  output logic                     flush
`ifdef HAZARD_PERF_EN
  , output logic [PERF_W-1:0]      perf_stall_cnt,
  output logic [PERF_W-1:0]        perf_fwd_cnt
`endif
);

  // Counter only ever holds MUL_LAT-1 down to 0.
  localparam int              CNT_W     = $clog2(MUL_LAT);
  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(MUL_LAT - 1);

  stage_tag_t       idTag;
  stage_tag_t       exTag_p0;
  dst_tag_t         memTag_p1;
  dst_tag_t         wbTag_p2;
  logic [CNT_W-1:0] busyCnt_p0;
  logic             busy;
  logic             loadUse;
  fwd_sel_e         portSel [NUM_RD];

  function automatic logic dstHits(input dst_tag_t d, input logic [REG_AW-1:0] rs);
    return d.valid && d.regWrite && (d.rd == rs) && (d.rd != REG_ZERO);
  endfunction

  always_comb begin
    idTag = TAG_BUBBLE;
    if (id_valid) begin
      idTag.valid    = 1'b1;
      idTag.regWrite = id_reg_write;
      idTag.memRead  = id_mem_read;
      idTag.multi    = id_multi;
      idTag.rd       = id_rd_addr;
      idTag.used     = id_rs_used;
      for (int i = 0; i < NUM_RD; i++) begin
        idTag.rs[i] = id_rs_addr[i*REG_AW +: REG_AW];
      end
    end
  end

  // The counter is only loaded by a multi op entering EX, so qualifying it
  // with the EX tag keeps a stray count from freezing an unrelated op.
  assign busy = (busyCnt_p0 != '0) && exTag_p0.multi;

  always_comb begin
    loadUse = 1'b0;
    if (id_valid && exTag_p0.valid && exTag_p0.memRead && (exTag_p0.rd != REG_ZERO)) begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (id_rs_used[i] && (id_rs_addr[i*REG_AW +: REG_AW] == exTag_p0.rd)) begin
          loadUse = 1'b1;
        end
      end
    end
  end

  // Reset gates the combinational outputs too, since the branch input is
  // not registered here.
  assign flush = !Reset && ex_branch_taken && !busy;
  assign stall = !Reset && (busy || (loadUse && !ex_branch_taken));

  // Stage boundary: ID -> EX -> MEM -> WB tag pipeline
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      exTag_p0   <= TAG_BUBBLE;
      memTag_p1  <= DST_BUBBLE;
      wbTag_p2   <= DST_BUBBLE;
      busyCnt_p0 <= '0;
    end else begin
      wbTag_p2 <= memTag_p1;
      if (busy) begin
        memTag_p1  <= DST_BUBBLE;
        busyCnt_p0 <= busyCnt_p0 - CNT_W'(1);
      end else begin
        memTag_p1 <= dstOf(exTag_p0);
        if (ex_branch_taken || loadUse) begin
          exTag_p0 <= TAG_BUBBLE;
        end else begin
          exTag_p0 <= idTag;
          if (idTag.multi) begin
            busyCnt_p0 <= BUSY_LOAD;
          end
        end
      end
    end
  end

  // Newest producer wins: MEM is checked before WB.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      portSel[i] = FWD_RF;
      if (exTag_p0.used[i] && (exTag_p0.rs[i] != REG_ZERO)) begin
        if (dstHits(memTag_p1, exTag_p0.rs[i])) begin
          portSel[i] = FWD_MEM;
        end else if (dstHits(wbTag_p2, exTag_p0.rs[i])) begin
          portSel[i] = FWD_WB;
        end
      end
      fwd_sel[2*i +: 2] = portSel[i];
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : gFwdMux
    operand_fwd_mux #(
      .DATA_W (DATA_W)
    ) uMux (
      .sel     (portSel[g]),
      .rfData  (ex_rs_data[g*DATA_W +: DATA_W]),
      .wbData  (memwb_result),
      .memData (exmem_result),
      .opnd    (ex_opnd[g*DATA_W +: DATA_W])
    );
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] perfStall_p0;
  logic [PERF_W-1:0] perfFwd_p0;

  function automatic logic [PERF_W-1:0] satInc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  // Stage boundary: perf counters sampled at each clock
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      perfStall_p0 <= '0;
      perfFwd_p0   <= '0;
    end else begin
      if (stall) begin
        perfStall_p0 <= satInc(perfStall_p0);
      end
      if (|fwd_sel) begin
        perfFwd_p0 <= satInc(perfFwd_p0);
      end
    end
  end

  assign perf_stall_cnt = perfStall_p0;
  assign perf_fwd_cnt   = perfFwd_p0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit
//   Directed instruction sequences for hazard_forward_unit. The driver pushes
//   the expected outputs of each cycle into a scoreboard queue; a monitor on
//   the falling edge pops and compares. Define HAZARD_PERF_EN to also check
//   the perf counters.
module tb_hazard_forward_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        id_valid;
  logic [9:0]  id_rs_addr;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd_addr;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_multi;
  logic        ex_branch_taken;
  logic [63:0] ex_rs_data;
  logic [31:0] exmem_result;
  logic [31:0] memwb_result;
  logic [63:0] ex_opnd;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic        flush;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_fwd_cnt;
`endif

  hazard_forward_unit #(
    .DATA_W  (32),
    .REG_AW  (5),
    .NUM_RD  (2),
    .MUL_LAT (4)
`ifdef HAZARD_PERF_EN
    , .PERF_W (32)
`endif
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .id_valid        (id_valid),
    .id_rs_addr      (id_rs_addr),
    .id_rs_used      (id_rs_used),
    .id_rd_addr      (id_rd_addr),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_multi        (id_multi),
    .ex_branch_taken (ex_branch_taken),
    .ex_rs_data      (ex_rs_data),
    .exmem_result    (exmem_result),
    .memwb_result    (memwb_result),
    .ex_opnd         (ex_opnd),
    .fwd_sel         (fwd_sel),
    .stall           (stall),
    .flush           (flush)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt (perf_stall_cnt),
    .perf_fwd_cnt    (perf_fwd_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  localparam logic [63:0] RF  = {32'h0000_0200, 32'h0000_0100};
  localparam logic [31:0] MEMV = 32'd7;
  localparam logic [31:0] WBV  = 32'h55;

  typedef struct packed {
    int          cyc;
    bit          chkS;
    logic        s;
    bit          chkF;
    logic        f;
    bit          chkSel;
    logic [3:0]  sel;
    bit          chkOp;
    logic [63:0] op;
    bit          chkPerf;
    logic [31:0] pStall;
    logic [31:0] pFwd;
  } exp_t;

  exp_t  sbq [$];
  string nameQ [$];
  int    nChecks = 0;
  int    nErr = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
    nChecks++;
    if (act !== req) begin
      nErr++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic push(input string nm, input bit cs, input logic s, input bit cf, input logic f,
                      input bit csel, input logic [3:0] sel, input bit cop, input logic [63:0] op);
    exp_t e;
    e = '0;
    e.cyc = cyc; e.chkS = cs; e.s = s; e.chkF = cf; e.f = f;
    e.chkSel = csel; e.sel = sel; e.chkOp = cop; e.op = op;
    sbq.push_back(e);
    nameQ.push_back(nm);
  endtask

  task automatic expAll(input string nm, input logic s, input logic f, input logic [3:0] sel,
                        input logic [63:0] op);
    push(nm, 1, s, 1, f, 1, sel, 1, op);
  endtask

  task automatic expSF(input string nm, input logic s, input logic f);
    push(nm, 1, s, 1, f, 0, 4'b0, 0, 64'b0);
  endtask

`ifdef HAZARD_PERF_EN
  task automatic expPerf(input string nm, input logic [31:0] ps, input logic [31:0] pf);
    exp_t e;
    e = '0;
    e.cyc = cyc; e.chkPerf = 1; e.pStall = ps; e.pFwd = pf;
    sbq.push_back(e);
    nameQ.push_back(nm);
  endtask
`endif

  // Monitor: compare every entry scheduled for the current cycle.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge Clk);
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e  = sbq.pop_front();
        nm = nameQ.pop_front();
        if (e.cyc != cyc) begin
          cmp({nm, "_cycle"}, 64'(cyc), 64'(e.cyc));
        end else begin
          if (e.chkS)   cmp({nm, "_stall"}, 64'(stall), 64'(e.s));
          if (e.chkF)   cmp({nm, "_flush"}, 64'(flush), 64'(e.f));
          if (e.chkSel) cmp({nm, "_fwd_sel"}, 64'(fwd_sel), 64'(e.sel));
          if (e.chkOp)  cmp({nm, "_ex_opnd"}, ex_opnd, e.op);
`ifdef HAZARD_PERF_EN
          if (e.chkPerf) begin
            cmp({nm, "_perf_stall"}, 64'(perf_stall_cnt), 64'(e.pStall));
            cmp({nm, "_perf_fwd"}, 64'(perf_fwd_cnt), 64'(e.pFwd));
          end
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic nop();
    id_valid = 0; id_rs_addr = '0; id_rs_used = '0; id_rd_addr = '0;
    id_reg_write = 0; id_mem_read = 0; id_multi = 0;
  endtask

  task automatic setId(input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic mul);
    id_valid = 1; id_rs_addr = {rs1, rs0}; id_rs_used = used; id_rd_addr = rd;
    id_reg_write = rw; id_mem_read = mr; id_multi = mul;
  endtask

  task automatic drain();
    nop();
    repeat (3) step();
  endtask

  initial begin
    nop();
    ex_branch_taken = 0;
    ex_rs_data      = RF;
    exmem_result    = MEMV;
    memwb_result    = WBV;
    step(); step();

    // Reset: outputs quiet even with a branch and a hazard-looking ID instr
    ex_branch_taken = 1;
    setId(5'd4, 5'd4, 2'b11, 5'd5, 1, 0, 0);
    expAll("rst", 0, 0, 4'b0000, RF);
    step();
    Reset = 0; ex_branch_taken = 0; nop();
    step();

    // 1: add r1; add r2,r1,r1 -> both ports from MEM
    setId(5'd10, 5'd11, 2'b11, 5'd1, 1, 0, 0);
    expAll("t1_idle", 0, 0, 4'b0000, RF);
    step(); setId(5'd1, 5'd1, 2'b11, 5'd2, 1, 0, 0);
    expSF("t1_no_stall", 0, 0);
    step(); nop();
    expAll("t1_fwd_mem", 0, 0, 4'b1010, {MEMV, MEMV});
    drain();

    // 2: add r1; nop; sub r3,r1,r0 -> port0 WB, port1 regfile
    setId(5'd10, 5'd11, 2'b11, 5'd1, 1, 0, 0);
    step(); nop();
    step(); setId(5'd1, 5'd0, 2'b11, 5'd3, 1, 0, 0);
    expAll("t2_ex_bubble", 0, 0, 4'b0000, RF);
    step(); nop();
    expAll("t2_fwd_wb", 0, 0, 4'b0001, {32'h0000_0200, WBV});
    drain();

    // 3: two writers of r3 in MEM and WB; port1 reads r3 but is unused
    setId(5'd10, 5'd11, 2'b11, 5'd3, 1, 0, 0);
    step(); setId(5'd10, 5'd11, 2'b11, 5'd3, 1, 0, 0);
    step(); setId(5'd3, 5'd3, 2'b01, 5'd4, 1, 0, 0);
    step(); nop();
    expAll("t3_mem_wins", 0, 0, 4'b0010, {32'h0000_0200, MEMV});
    drain();

    // 4: lw r4; add r5,r4,r4 -> one stall, bubble, then WB on both ports
    setId(5'd0, 5'd0, 2'b00, 5'd4, 1, 1, 0);
    step(); setId(5'd4, 5'd4, 2'b11, 5'd5, 1, 0, 0);
    expSF("t4_loaduse", 1, 0);
    step();
    expAll("t4_bubble", 0, 0, 4'b0000, RF);
    step(); nop();
    expAll("t4_fwd_wb", 0, 0, 4'b0101, {WBV, WBV});
    drain();
`ifdef HAZARD_PERF_EN
    expPerf("t4_perf", 32'd1, 32'd4);
`endif

    // 5: mul r6; add r7,r6 -> three stall cycles, branch ignored while busy
    setId(5'd0, 5'd0, 2'b00, 5'd6, 1, 0, 1);
    step(); setId(5'd6, 5'd0, 2'b01, 5'd7, 1, 0, 0);
    expSF("t5_busy1", 1, 0);
    step(); ex_branch_taken = 1;
    expSF("t5_busy2_br", 1, 0);
    step(); ex_branch_taken = 0;
    expSF("t5_busy3", 1, 0);
    step();
    expAll("t5_release", 0, 0, 4'b0000, RF);
    step(); nop();
    expAll("t5_fwd_mem", 0, 0, 4'b0010, {32'h0000_0200, MEMV});
    drain();

    // 5b: Reset during busy cycle 2 -> stall drops at once
    setId(5'd0, 5'd0, 2'b00, 5'd6, 1, 0, 1);
    step(); setId(5'd6, 5'd0, 2'b01, 5'd7, 1, 0, 0);
    step(); Reset = 1;
    expAll("t5_rst_mid", 0, 0, 4'b0000, RF);
    step(); Reset = 0;
    expSF("t5_after_rst", 0, 0);
`ifdef HAZARD_PERF_EN
    expPerf("t5_perf_clr", 32'd0, 32'd0);
`endif
    step(); nop();
    expSF("t5_no_restall", 0, 0);
    drain();

    // 6: write to r0 is never forwarded
    setId(5'd10, 5'd11, 2'b11, 5'd0, 1, 0, 0);
    step(); setId(5'd0, 5'd0, 2'b11, 5'd8, 1, 0, 0);
    step(); nop();
    expAll("t6_r0", 0, 0, 4'b0000, RF);
    drain();

    // 6b: load-use with a taken branch -> flush wins, no stall
    setId(5'd0, 5'd0, 2'b00, 5'd4, 1, 1, 0);
    step(); setId(5'd4, 5'd4, 2'b11, 5'd5, 1, 0, 0); ex_branch_taken = 1;
    expSF("t6_flush", 0, 1);
    step(); ex_branch_taken = 0; nop();
    expAll("t6_after_flush", 0, 0, 4'b0000, RF);
    drain();

    for (int k = 0; k < 20 && sbq.size() != 0; k++) @(posedge Clk);
    if (sbq.size() != 0) begin
      nChecks++;
      nErr++;
      $display("FAIL scoreboard_drain: pending %0d, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
